// File: rtl/countdown_timer_param_if.sv
// Control/status bundle between the control FSM and the countdown timer.
interface countdown_timer_param_if #(
  parameter int unsigned WIDTH = 9
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             pause;
  logic             reload_en;
  logic [WIDTH-1:0] current;
  logic             running;
  logic             done;
  logic             expired;

  // Controller side: issues strobes, observes count and status.
  modport master (
    output load, load_value, start, pause, reload_en,
    input  current, running, done, expired
  );

  // Timer side.
  modport slave (
    input  load, load_value, start, pause, reload_en,
    output current, running, done, expired
  );
endinterface

// File: rtl/countdown_timer_param.sv
// Programmable countdown timer with prescaler, pause/resume, and one-shot or auto-reload mode.
// All outputs come straight from registers.
module countdown_timer_param #(
  parameter int unsigned WIDTH    = 9,
  parameter int unsigned PRESCALE = 1
) (
  input logic                    clock,
  input logic                    reset,
  countdown_timer_param_if.slave bus
);

  localparam int unsigned     PW       = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0]   PresLast = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]   PresOne  = PW'(1);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] current_q, current_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic             tick;

  assign tick = (presc_q == PresLast);

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      current_q <= '0;
      reload_q  <= '0;
      presc_q   <= '0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      current_q <= current_d;
      reload_q  <= reload_d;
      presc_q   <= presc_d;
      done_q    <= done_d;
      expired_q <= expired_d;
    end
  end

  // Next-state logic: load beats start/pause, which beat the count tick.
  always_comb begin
    state_d   = state_q;
    current_d = current_q;
    reload_d  = reload_q;
    presc_d   = presc_q;
    done_d    = 1'b0;
    expired_d = expired_q;

    if (bus.load) begin
      reload_d  = bus.load_value;
      current_d = bus.load_value;
      presc_d   = '0;
      expired_d = 1'b0;
      state_d   = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start && (current_q != '0)) begin
            state_d = StRun;
            presc_d = '0;
          end
        end
        StRun: begin
          // Pause freezes the prescaler too, so resume continues the partial period.
          if (bus.pause) begin
            state_d = StPause;
          end else if (tick) begin
            presc_d = '0;
            if (current_q > One) begin
              current_d = current_q - One;
            end else if (current_q == One) begin
              done_d = 1'b1;
              if (bus.reload_en) begin
                current_d = reload_q;
              end else begin
                current_d = '0;
                expired_d = 1'b1;
                state_d   = StExpired;
              end
            end
          end else begin
            presc_d = presc_q + PresOne;
          end
        end
        StPause: begin
          if (bus.start) begin
            state_d = StRun;
          end
        end
        StExpired: begin
          if (bus.start && (reload_q != '0)) begin
            current_d = reload_q;
            expired_d = 1'b0;
            presc_d   = '0;
            state_d   = StRun;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Registered status outputs.
  always_comb begin
    bus.current = current_q;
    bus.running = (state_q == StRun);
    bus.done    = done_q;
    bus.expired = expired_q;
  end

endmodule

// File: tb/tb_countdown_timer_param.sv
// Bench for countdown_timer_param: vector tables through a scoreboard queue, plus
// hand-written prescaler/pause and asynchronous-reset sequences.
module tb_countdown_timer_param;
  localparam int unsigned W = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_param_if #(.WIDTH(W)) bus1 ();
  countdown_timer_param_if #(.WIDTH(W)) bus4 ();

  countdown_timer_param #(.WIDTH(W), .PRESCALE(1)) dut1 (
    .clock (clk),
    .reset (rst),
    .bus   (bus1)
  );

  countdown_timer_param #(.WIDTH(W), .PRESCALE(4)) dut4 (
    .clock (clk),
    .reset (rst),
    .bus   (bus4)
  );

  typedef struct {
    logic         ld;
    logic [W-1:0] lv;
    logic         st;
    logic         pa;
    logic         re;
    logic [W-1:0] cur;
    logic         run;
    logic         dn;
    logic         ex;
  } vec_t;

  typedef struct {
    logic [W-1:0] cur;
    logic         run;
    logic         dn;
    logic         ex;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic ld, input logic [W-1:0] lv, input logic st,
                              input logic pa, input logic re, input logic [W-1:0] cur,
                              input logic run, input logic dn, input logic ex);
    vec_t v;
    v.ld = ld; v.lv = lv; v.st = st; v.pa = pa; v.re = re;
    v.cur = cur; v.run = run; v.dn = dn; v.ex = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic clear_inputs();
    bus1.load = 1'b0; bus1.load_value = '0; bus1.start = 1'b0;
    bus1.pause = 1'b0; bus1.reload_en = 1'b0;
    bus4.load = 1'b0; bus4.load_value = '0; bus4.start = 1'b0;
    bus4.pause = 1'b0; bus4.reload_en = 1'b0;
  endtask

  // One clock: drive at negedge, queue expected, compare just after the rising edge.
  task automatic step(input vec_t v, input bit sel4, input string tag);
    exp_t e;
    exp_t g;
    @(negedge clk);
    clear_inputs();
    if (sel4) begin
      bus4.load = v.ld; bus4.load_value = v.lv; bus4.start = v.st;
      bus4.pause = v.pa; bus4.reload_en = v.re;
    end else begin
      bus1.load = v.ld; bus1.load_value = v.lv; bus1.start = v.st;
      bus1.pause = v.pa; bus1.reload_en = v.re;
    end
    e.cur = v.cur; e.run = v.run; e.dn = v.dn; e.ex = v.ex;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sel4) begin
      g.cur = bus4.current; g.run = bus4.running; g.dn = bus4.done; g.ex = bus4.expired;
    end else begin
      g.cur = bus1.current; g.run = bus1.running; g.dn = bus1.done; g.ex = bus1.expired;
    end
    e = sb_q.pop_front();
    chk({tag, ".current"}, g.cur, e.cur);
    chk({tag, ".running"}, W'(g.run), W'(e.run));
    chk({tag, ".done"}, W'(g.dn), W'(e.dn));
    chk({tag, ".expired"}, W'(g.ex), W'(e.ex));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();

    // One-shot count from 5, PRESCALE=1.
    tbl.push_back(mk(1, 5, 0, 0, 0, 5, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Pause at 3 (pause beats start), held, resumed by start+pause (start beats pause).
    tbl.push_back(mk(1, 8, 0, 0, 0, 8, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 8, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 7, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 6, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 5, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 3, 0, 0, 0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(0, 0, 0, (i == 3), 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Auto-reload from 2, then drop reload_en.
    tbl.push_back(mk(1, 2, 0, 0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 1, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1));
    // Load+start while running: load wins, no counting; then restart from EXPIRED.
    tbl.push_back(mk(1, 3, 0, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1, 7, 1, 0, 0, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 7, 0, 0, 0));
    tbl.push_back(mk(1, 4, 0, 0, 0, 4, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 3, 1, 0, 0));

    // Reset state, sampled between edges while reset is held.
    #12;
    chk("rst1.current", bus1.current, '0);
    chk("rst1.running", W'(bus1.running), '0);
    chk("rst1.done", W'(bus1.done), '0);
    chk("rst1.expired", W'(bus1.expired), '0);
    chk("rst4.current", bus4.current, '0);
    chk("rst4.expired", W'(bus4.expired), '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // PRESCALE=4: load 3, start; one decrement every 4 edges, done on the 12th.
    step(mk(1, 3, 0, 0, 0, 3, 0, 0, 0), 1'b1, "ps_load");
    step(mk(0, 0, 1, 0, 0, 3, 1, 0, 0), 1'b1, "ps_start");
    for (int k = 1; k <= 12; k++) begin
      step(mk(0, 0, 0, 0, 0, W'(3 - k / 4), (k != 12), (k == 12), (k == 12)), 1'b1,
           $sformatf("ps_edge%0d", k));
    end
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 1), 1'b1, "ps_after");

    // PRESCALE=4 pause after two prescaler counts: partial period resumes as held.
    step(mk(1, 2, 0, 0, 0, 2, 0, 0, 0), 1'b1, "pp_load");
    step(mk(0, 0, 1, 0, 0, 2, 1, 0, 0), 1'b1, "pp_start");
    step(mk(0, 0, 0, 0, 0, 2, 1, 0, 0), 1'b1, "pp_e1");
    step(mk(0, 0, 0, 0, 0, 2, 1, 0, 0), 1'b1, "pp_e2");
    step(mk(0, 0, 0, 1, 0, 2, 0, 0, 0), 1'b1, "pp_pause");
    step(mk(0, 0, 0, 0, 0, 2, 0, 0, 0), 1'b1, "pp_held");
    step(mk(0, 0, 1, 0, 0, 2, 1, 0, 0), 1'b1, "pp_resume");
    step(mk(0, 0, 0, 0, 0, 2, 1, 0, 0), 1'b1, "pp_e6");
    step(mk(0, 0, 0, 0, 0, 1, 1, 0, 0), 1'b1, "pp_e7");
    for (int k = 8; k <= 10; k++) step(mk(0, 0, 0, 0, 0, 1, 1, 0, 0), 1'b1, "pp_wait");
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 1), 1'b1, "pp_done");

    // Asynchronous reset in the middle of a count.
    step(mk(1, 6, 0, 0, 0, 6, 0, 0, 0), 1'b0, "ar_load");
    step(mk(0, 0, 1, 0, 0, 6, 1, 0, 0), 1'b0, "ar_start");
    step(mk(0, 0, 0, 0, 0, 5, 1, 0, 0), 1'b0, "ar_run");
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_async.current", bus1.current, '0);
    chk("ar_async.running", W'(bus1.running), '0);
    chk("ar_async.done", W'(bus1.done), '0);
    @(negedge clk);
    rst = 1'b0;
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, "ar_start_ign");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "ar_load0");
    step(mk(0, 0, 1, 0, 0, 0, 0, 0, 0), 1'b0, "ar_start0_ign");
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0, "ar_still_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
